// File: rtl/axi_offset_programmer.sv
// Programs one offset word into an AXI-Lite slave register and reads it back to verify.
// Failed verifies are retried up to MAX_RETRIES times; a stalled handshake aborts the attempt.
module axi_offset_programmer #(
    parameter int AXI_ADDR_WIDTH_SLAVE = 5,
    parameter int AXI_DATA_WIDTH       = 32,
    parameter int CFG_ADDR             = 0,
    parameter int MAX_RETRIES          = 3,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [AXI_DATA_WIDTH-1:0]       cmd_offset,
    output logic                            done,
    output logic                            error,
    output logic [AXI_ADDR_WIDTH_SLAVE-1:0] m00_axi_awaddr,
    output logic                            m00_axi_awvalid,
    input  logic                            m00_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]       m00_axi_wdata,
    output logic                            m00_axi_wvalid,
    input  logic                            m00_axi_wready,
    input  logic                            m00_axi_bvalid,
    output logic                            m00_axi_bready,
    input  logic [1:0]                      m00_axi_bresp,
    output logic [AXI_ADDR_WIDTH_SLAVE-1:0] m00_axi_araddr,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]       m00_axi_rdata,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,
    input  logic [1:0]                      m00_axi_rresp
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [AXI_ADDR_WIDTH_SLAVE-1:0] CFG_ADDR_V = AXI_ADDR_WIDTH_SLAVE'(CFG_ADDR);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [1:0]    RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t                    state_r, state_n_s;
    logic [AXI_DATA_WIDTH-1:0] offset_r, offset_n_s;
    logic [RW-1:0]             retry_r, retry_n_s;
    logic [TW-1:0]             tmo_r, tmo_n_s;
    logic                      aw_done_r, aw_done_n_s;
    logic                      w_done_r, w_done_n_s;
    logic                      awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
    logic                      done_r, error_r, done_n_s, error_n_s;
    logic                      retry_s;

    // Next-state, retry and timeout decisions
    always_comb begin
        state_n_s   = state_r;
        offset_n_s  = offset_r;
        retry_n_s   = retry_r;
        aw_done_n_s = aw_done_r;
        w_done_n_s  = w_done_r;
        done_n_s    = 1'b0;
        error_n_s   = 1'b0;
        retry_s     = 1'b0;
        tmo_n_s     = '0;

        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    offset_n_s  = cmd_offset;
                    retry_n_s   = '0;
                    aw_done_n_s = 1'b0;
                    w_done_n_s  = 1'b0;
                    state_n_s   = WR;
                end else begin
                    state_n_s = IDLE;
                end
            end
            WR: begin
                aw_done_n_s = aw_done_r | (awvalid_r & m00_axi_awready);
                w_done_n_s  = w_done_r | (wvalid_r & m00_axi_wready);
                if (aw_done_n_s && w_done_n_s) begin
                    state_n_s = WR_RESP;
                end else begin
                    state_n_s = WR;
                end
            end
            WR_RESP: begin
                if (bready_r && m00_axi_bvalid) begin
                    if (m00_axi_bresp == RESP_OKAY) begin
                        state_n_s = RD_ADDR;
                    end else begin
                        retry_s = 1'b1;
                    end
                end else begin
                    state_n_s = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (arvalid_r && m00_axi_arready) begin
                    state_n_s = RD_DATA;
                end else begin
                    state_n_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rready_r && m00_axi_rvalid) begin
                    if (m00_axi_rresp == RESP_OKAY && m00_axi_rdata == offset_r) begin
                        done_n_s  = 1'b1;
                        state_n_s = IDLE;
                    end else begin
                        retry_s = 1'b1;
                    end
                end else begin
                    state_n_s = RD_DATA;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase

        if (retry_s) begin
            if (retry_r < RETRY_MAX) begin
                retry_n_s   = retry_r + 1'b1;
                aw_done_n_s = 1'b0;
                w_done_n_s  = 1'b0;
                state_n_s   = WR;
            end else begin
                error_n_s = 1'b1;
                state_n_s = IDLE;
            end
        end else begin
            retry_n_s = retry_n_s;
        end

        // Progress on the final allowed cycle wins over the abort
        if (state_r != IDLE && state_n_s == state_r && tmo_r == TMO_LAST) begin
            error_n_s = 1'b1;
            state_n_s = IDLE;
        end else begin
            error_n_s = error_n_s;
        end

        if (state_n_s != state_r || state_r == IDLE) begin
            tmo_n_s = '0;
        end else begin
            tmo_n_s = tmo_r + 1'b1;
        end
    end

    // State, counters and registered handshake outputs
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            state_r   <= IDLE;
            offset_r  <= '0;
            retry_r   <= '0;
            tmo_r     <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            offset_r  <= offset_n_s;
            retry_r   <= retry_n_s;
            tmo_r     <= tmo_n_s;
            aw_done_r <= aw_done_n_s;
            w_done_r  <= w_done_n_s;
            awvalid_r <= (state_n_s == WR) && !aw_done_n_s;
            wvalid_r  <= (state_n_s == WR) && !w_done_n_s;
            bready_r  <= (state_n_s == WR_RESP);
            arvalid_r <= (state_n_s == RD_ADDR);
            rready_r  <= (state_n_s == RD_DATA);
            done_r    <= done_n_s;
            error_r   <= error_n_s;
        end
    end

    assign cmd_ready       = (state_r == IDLE);
    assign done            = done_r;
    assign error           = error_r;
    assign m00_axi_awaddr  = CFG_ADDR_V;
    assign m00_axi_araddr  = CFG_ADDR_V;
    assign m00_axi_wdata   = offset_r;
    assign m00_axi_awvalid = awvalid_r;
    assign m00_axi_wvalid  = wvalid_r;
    assign m00_axi_bready  = bready_r;
    assign m00_axi_arvalid = arvalid_r;
    assign m00_axi_rready  = rready_r;

endmodule

// File: doc/axi_offset_programmer.md
AXI_OFFSET_PROGRAMMER -- requirements
Module: axi_offset_programmer

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH_SLAVE, default 5, AXI-Lite config address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data/offset width.
REQ-003 SHALL have parameter CFG_ADDR, default 0, byte address of the offset register written and verified.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, number of re-attempts after a failed verify.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait cycles per handshake phase.
REQ-006 SHALL have port s00_axi_aclk  in  1  sole clock, rising edge.
REQ-007 SHALL have port s00_axi_areset  in  1  reset, asynchronous and active-high.
REQ-008 SHALL have port cmd_valid  in  1  new offset request.
REQ-009 SHALL have port cmd_ready  out  1  block idle, request accepted.
REQ-010 SHALL have port cmd_offset  in  AXI_DATA_WIDTH  offset to program.
REQ-011 SHALL have port done  out  1  one-cycle pulse, offset written and verified.
REQ-012 SHALL have port error  out  1  one-cycle pulse, retries exhausted or timeout.
REQ-013 SHALL have master write ports m00_axi_awaddr out AXI_ADDR_WIDTH_SLAVE, m00_axi_awvalid out 1, m00_axi_awready in 1.
REQ-014 SHALL have m00_axi_wdata out AXI_DATA_WIDTH, m00_axi_wvalid out 1, m00_axi_wready in 1.
REQ-015 SHALL have m00_axi_bvalid in 1, m00_axi_bready out 1, m00_axi_bresp in 2.
REQ-016 SHALL have master read ports m00_axi_araddr out AXI_ADDR_WIDTH_SLAVE, m00_axi_arvalid out 1, m00_axi_arready in 1.
REQ-017 SHALL have m00_axi_rdata in AXI_DATA_WIDTH, m00_axi_rvalid in 1, m00_axi_rready out 1, m00_axi_rresp in 2.

Function
REQ-018 SHALL implement states IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA; cmd_ready = (state==IDLE).
REQ-019 IDLE: cmd_valid -> capture cmd_offset, clear retry and timeout counters, enter WR next cycle.
REQ-020 WR: awvalid and wvalid asserted together; each drops the cycle after its own handshake; when both done -> WR_RESP.
REQ-021 WR_RESP: bready=1; bvalid with bresp==OKAY -> RD_ADDR; non-OKAY bresp -> retry path.
REQ-022 RD_ADDR: arvalid=1 until arready handshake -> RD_DATA; RD_DATA: rready=1 until rvalid.
REQ-023 RD_DATA on rvalid: rresp==OKAY and rdata==captured offset -> done pulse, IDLE; else retry path.
REQ-024 Retry path: retry counter < MAX_RETRIES -> increment, restart at WR; else error pulse, IDLE.
REQ-025 awaddr and araddr SHALL equal CFG_ADDR; wdata SHALL equal the captured offset, stable throughout the attempt.
REQ-026 Timeout counter SHALL clear on every state change and count cycles in WR, WR_RESP, RD_ADDR, RD_DATA.
REQ-027 Counter reaching TIMEOUT_CYCLES -> deassert all valid/ready, error pulse, IDLE (deliberate abort, no retry).
REQ-028 done and error SHALL never be asserted in the same cycle; neither asserted outside the terminating cycle.
REQ-029 cmd_valid while busy SHALL be ignored; cmd_offset changes after capture SHALL not affect the attempt.
REQ-030 Valid outputs SHALL not drop before handshake except on timeout or reset.

Reset
REQ-031 s00_axi_areset high SHALL immediately force IDLE, clear counters and captured offset, drive all valid/ready, done, error to 0, awaddr/araddr to CFG_ADDR, wdata to 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no done/error pulse; cmd_ready=1 in the first cycle after release.

Verification
REQ-033 Offset 0x0000_1000, responsive slave (zero-wait ready, OKAY, rdata matches) -> exactly one done pulse, one AW, one W, one AR, no error.
REQ-034 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, then normal completion with done.
REQ-035 Slave returns rdata 0xDEAD_BEEF against offset 0x0000_0040 on every read -> 4 write/read attempts (1+MAX_RETRIES), then one error pulse, no done.
REQ-036 First bresp=SLVERR, second attempt OKAY and match -> 2 write attempts, done pulse, retry counter cleared on next command.
REQ-037 arready never asserted -> arvalid held TIMEOUT_CYCLES cycles, then dropped, one error pulse, cmd_ready=1 next cycle.
REQ-038 Reset asserted during WR_RESP -> all master outputs idle asynchronously, no done/error; new command after release completes normally.
